// File: rtl/image_process_pkg.sv
// Shared constants, types and helpers for the streaming 3x3 Sobel edge detector.
package image_process_pkg;

    localparam int PIX_W = 8;
    localparam logic [9:0] K_EDGE = 10'd1;
    localparam logic [9:0] K_CENTER = 10'd2;
    localparam int THRESHOLD_DEFAULT = 4000;

    typedef enum logic {IDLE, READ} rd_state_t;

    typedef logic [1:0] line_sel_t;

    // One side of a Sobel kernel: a + 2b + c, at most 4*255 = 1020.
    function automatic logic [9:0] tap_sum(input logic [PIX_W-1:0] a,
                                           input logic [PIX_W-1:0] b,
                                           input logic [PIX_W-1:0] c);
        return K_EDGE * {2'b00, a} + K_CENTER * {2'b00, b} + K_EDGE * {2'b00, c};
    endfunction

endpackage

// File: rtl/image_process_top_line_buffer.sv
// One image line of pixel storage with a single write port and a 3-tap read window.
module line_buffer
    import image_process_pkg::*;
#(
    parameter int LINE_WIDTH = 256
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(LINE_WIDTH)-1:0] waddr,
    input  logic [PIX_W-1:0]              wdata,
    input  logic [$clog2(LINE_WIDTH)-1:0] rptr,
    output logic [3*PIX_W-1:0]            taps
);

    localparam int AW = $clog2(LINE_WIDTH);

    logic [PIX_W-1:0] mem [LINE_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Tap k is column rptr+k; columns past the end of the line read as zero.
    always_comb begin
        taps = '0;
        for (int k = 0; k < 3; k++) begin
            int col;
            col = int'(rptr) + k;
            if (col < LINE_WIDTH) taps[k*PIX_W +: PIX_W] = mem[col[AW-1:0]];
        end
    end

endmodule

// File: rtl/image_process_top.sv
// Streaming 3x3 Sobel edge detector: rotating line buffers, 3-stage gradient pipeline, FWFT output FIFO.
module image_process_top
    import image_process_pkg::*;
#(
    parameter int LINE_WIDTH     = 256,
    parameter int NUM_LINES      = 4,
    parameter int THRESHOLD      = THRESHOLD_DEFAULT,
    parameter int OUT_FIFO_DEPTH = 32
) (
    input  logic             axi_clk,
    input  logic             axi_reset_n,
    input  logic             i_data_valid,
    input  logic [PIX_W-1:0] i_data,
    output logic             o_data_ready,
    output logic             o_data_valid,
    output logic [PIX_W-1:0] o_data,
    input  logic             i_data_ready,
    output logic             o_intr
);

    localparam int AW  = $clog2(LINE_WIDTH);
    localparam int CW  = $clog2(4 * LINE_WIDTH + 1);
    localparam int FAW = $clog2(OUT_FIFO_DEPTH);

    line_sel_t wsel, rsel;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] pcnt;
    rd_state_t state, state_nxt;
    logic issue, finish;

    logic [FAW-1:0] fifo_wr, fifo_rd;
    logic [FAW:0] fifo_cnt;
    logic [PIX_W-1:0] fifo_mem [OUT_FIFO_DEPTH];
    logic almost_full, fifo_empty, push, pop;

    logic [3*PIX_W-1:0] taps [NUM_LINES];
    logic [3*PIX_W-1:0] row_t, row_m, row_b;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_lb
        line_buffer #(.LINE_WIDTH(LINE_WIDTH)) u_lb (
            .clk   (axi_clk),
            .we    (i_data_valid && (wsel == line_sel_t'(i))),
            .waddr (wptr),
            .wdata (i_data),
            .rptr  (rptr),
            .taps  (taps[i])
        );
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset_n) begin
            wptr <= '0;
            wsel <= '0;
        end else if (i_data_valid) begin
            if (wptr == AW'(LINE_WIDTH - 1)) begin
                wptr <= '0;
                wsel <= wsel + 2'd1;
            end else begin
                wptr <= wptr + AW'(1);
            end
        end
    end

    // Pixels stored but not yet consumed; a finished read line releases a whole line.
    always_ff @(posedge axi_clk) begin
        if (axi_reset_n) pcnt <= '0;
        else pcnt <= pcnt + CW'(i_data_valid) - (finish ? CW'(LINE_WIDTH) : '0);
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (pcnt >= CW'(3 * LINE_WIDTH)) state_nxt = READ;
            READ: begin
                if (!almost_full) begin
                    issue = 1'b1;
                    if (rptr == AW'(LINE_WIDTH - 1)) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset_n) begin
            state  <= IDLE;
            rptr   <= '0;
            rsel   <= '0;
            o_intr <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_intr <= finish;
            if (issue) rptr <= finish ? '0 : rptr + AW'(1);
            if (finish) rsel <= rsel + 2'd1;
        end
    end

    assign row_t = taps[rsel];
    assign row_m = taps[line_sel_t'(rsel + 2'd1)];
    assign row_b = taps[line_sel_t'(rsel + 2'd2)];

    logic s1_valid, s2_valid;
    logic [9:0] sum_r, sum_l, sum_b, sum_t;
    logic signed [10:0] gx, gy;
    logic signed [20:0] gx_e, gy_e, gx_sq, gy_sq;
    logic [20:0] mag;
    logic [PIX_W-1:0] edge_pix;

    // Stage 1: kernel side sums (right/left columns for Gx, bottom/top rows for Gy).
    always_ff @(posedge axi_clk) begin
        if (axi_reset_n) s1_valid <= 1'b0;
        else s1_valid <= issue;
        sum_r <= tap_sum(row_t[2*PIX_W +: PIX_W], row_m[2*PIX_W +: PIX_W], row_b[2*PIX_W +: PIX_W]);
        sum_l <= tap_sum(row_t[0 +: PIX_W], row_m[0 +: PIX_W], row_b[0 +: PIX_W]);
        sum_b <= tap_sum(row_b[0 +: PIX_W], row_b[PIX_W +: PIX_W], row_b[2*PIX_W +: PIX_W]);
        sum_t <= tap_sum(row_t[0 +: PIX_W], row_t[PIX_W +: PIX_W], row_t[2*PIX_W +: PIX_W]);
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset_n) s2_valid <= 1'b0;
        else s2_valid <= s1_valid;
        gx <= $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
        gy <= $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
    end

    // Stage 3 squares and thresholds straight into the FIFO; each square is below 2^20.
    assign gx_e     = 21'(gx);
    assign gy_e     = 21'(gy);
    assign gx_sq    = gx_e * gx_e;
    assign gy_sq    = gy_e * gy_e;
    assign mag      = $unsigned(gx_sq) + $unsigned(gy_sq);
    assign edge_pix = (mag > 21'(THRESHOLD)) ? {PIX_W{1'b1}} : '0;

    assign push        = s2_valid;
    assign fifo_empty  = (fifo_cnt == '0);
    assign pop         = !fifo_empty && i_data_ready;
    assign almost_full = (fifo_cnt >= (FAW+1)'(OUT_FIFO_DEPTH - 8));

    always_ff @(posedge axi_clk) begin
        if (push) fifo_mem[fifo_wr] <= edge_pix;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset_n) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) fifo_wr <= fifo_wr + FAW'(1);
            if (pop) fifo_rd <= fifo_rd + FAW'(1);
            fifo_cnt <= fifo_cnt + (FAW+1)'(push) - (FAW+1)'(pop);
        end
    end

    assign o_data_valid = !fifo_empty;
    assign o_data       = fifo_empty ? '0 : fifo_mem[fifo_rd];
    assign o_data_ready = !axi_reset_n && !almost_full;

endmodule

// File: tb/tb_image_process_top.sv
// Directed self-checking bench for image_process_top using 8-pixel lines and constant-valued lines.
`timescale 1ns/1ps
module tb_image_process_top;

    localparam int LW = 8;

    logic       axi_clk = 1'b0;
    logic       axi_reset_n;
    logic       i_data_valid;
    logic [7:0] i_data;
    logic       o_data_ready;
    logic       o_data_valid;
    logic [7:0] o_data;
    logic       i_data_ready;
    logic       o_intr;

    int checks = 0;
    int passes = 0;
    int intr_cnt = 0;
    int out_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] vals [10];

    always #5 axi_clk = ~axi_clk;

    image_process_top #(
        .LINE_WIDTH(LW), .NUM_LINES(4), .THRESHOLD(4000), .OUT_FIFO_DEPTH(32)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .i_data_ready (i_data_ready),
        .o_intr       (o_intr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Reference Sobel for three constant-valued lines, with zero padding past the line end.
    function automatic logic [7:0] sobel_ref(input int t, input int m, input int b, input int col);
        int p[9];
        int v[3];
        int gx, gy;
        v = '{t, m, b};
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                p[r*3+k] = (col + k < LW) ? v[r] : 0;
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        return (gx*gx + gy*gy > 4000) ? 8'hFF : 8'h00;
    endfunction

    // Output monitor: every accepted pixel is compared against the scoreboard.
    always @(negedge axi_clk) begin
        if (o_intr) intr_cnt++;
        if (!axi_reset_n && o_data_valid && i_data_ready) begin
            out_cnt++;
            if (exp_q.size() > 0) checkOutput("out_pix", o_data, exp_q.pop_front());
            else checkOutput("extra_out", 32'(exp_q.size()), 32'd1);
        end
    end

    task automatic applyStimulus(input logic [7:0] val);
        for (int c = 0; c < LW; c++) begin
            i_data_valid = 1'b1;
            i_data       = val;
            @(posedge axi_clk); #1;
        end
        i_data_valid = 1'b0;
        i_data       = 8'd0;
    endtask

    task automatic resetDut(input int cycles);
        axi_reset_n  = 1'b1;
        i_data_valid = 1'b0;
        repeat (cycles) begin @(posedge axi_clk); #1; end
        axi_reset_n = 1'b0;
        exp_q.delete();
        intr_cnt = 0;
        out_cnt  = 0;
    endtask

    task automatic pushRead(input int t, input int m, input int b);
        for (int c = 0; c < LW; c++) exp_q.push_back(sobel_ref(t, m, b, c));
    endtask

    task automatic waitIntrCount(input int target);
        for (int n = 0; n < 1000 && intr_cnt < target; n++) begin @(posedge axi_clk); #1; end
        checkOutput("intr_wait", 32'(intr_cnt >= target), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && exp_q.size() > 0; n++) begin @(posedge axi_clk); #1; end
        repeat (10) begin @(posedge axi_clk); #1; end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] pat_const [8];
        pat_const = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        for (int k = 0; k < 10; k++) vals[k] = 8'((k * 53 + 7) % 256);

        axi_reset_n  = 1'b1;
        i_data_valid = 1'b0;
        i_data       = 8'd0;
        i_data_ready = 1'b1;

        // Reset held with random input traffic: all outputs quiet.
        for (int n = 0; n < 10; n++) begin
            i_data_valid = 1'($urandom_range(0, 1));
            i_data       = 8'($urandom);
            @(posedge axi_clk); #1;
            checkOutput("rst_valid", o_data_valid, 1'b0);
            checkOutput("rst_intr", o_intr, 1'b0);
            checkOutput("rst_ready", o_data_ready, 1'b0);
        end
        axi_reset_n  = 1'b0;
        i_data_valid = 1'b0;
        intr_cnt     = 0;
        out_cnt      = 0;
        @(posedge axi_clk); #1;
        checkOutput("post_rst_ready", o_data_ready, 1'b1);
        checkOutput("post_rst_valid", o_data_valid, 1'b0);
        repeat (20) begin @(posedge axi_clk); #1; end
        checkOutput("idle_out", out_cnt, 0);

        // Three constant lines of 50: only the zero-padded right edge fires.
        foreach (pat_const[c]) exp_q.push_back(pat_const[c]);
        applyStimulus(8'd50); applyStimulus(8'd50); applyStimulus(8'd50);
        checkOutput("pre_intr", intr_cnt, 0);
        drain();
        checkOutput("const_outs", out_cnt, 8);
        checkOutput("const_intr", intr_cnt, 1);

        // Horizontal edge 0,0,255: every column is an edge.
        resetDut(2);
        for (int c = 0; c < LW; c++) exp_q.push_back(8'hFF);
        applyStimulus(8'd0); applyStimulus(8'd0); applyStimulus(8'd255);
        drain();
        checkOutput("hedge_outs", out_cnt, 8);

        // Flat 10,10,10: padding gradient stays under threshold.
        resetDut(2);
        for (int c = 0; c < LW; c++) exp_q.push_back(8'h00);
        applyStimulus(8'd10); applyStimulus(8'd10); applyStimulus(8'd10);
        drain();
        checkOutput("flat_outs", out_cnt, 8);

        // Rotating buffers: 4 lines up front, then one line per interrupt, 10 lines total.
        resetDut(2);
        for (int r = 0; r < 8; r++) pushRead(vals[r], vals[r+1], vals[r+2]);
        for (int l = 0; l < 4; l++) applyStimulus(vals[l]);
        for (int l = 4; l < 10; l++) begin
            waitIntrCount(l - 3);
            applyStimulus(vals[l]);
        end
        drain();
        checkOutput("rot_intr", intr_cnt, 8);
        checkOutput("rot_outs", out_cnt, 8 * LW);

        // Sink back-pressure: FIFO reaches almost-full, the fourth read stalls.
        resetDut(2);
        i_data_ready = 1'b0;
        for (int r = 0; r < 4; r++) pushRead(vals[r], vals[r+1], vals[r+2]);
        for (int l = 0; l < 4; l++) applyStimulus(vals[l]);
        for (int l = 4; l < 6; l++) begin
            waitIntrCount(l - 3);
            applyStimulus(vals[l]);
        end
        repeat (60) begin @(posedge axi_clk); #1; end
        checkOutput("stall_intr", intr_cnt, 3);
        checkOutput("stall_ready", o_data_ready, 1'b0);
        checkOutput("stall_valid", o_data_valid, 1'b1);
        i_data_ready = 1'b1;
        drain();
        checkOutput("stall_outs", out_cnt, 4 * LW);
        checkOutput("stall_intr_end", intr_cnt, 4);

        // Reset in the middle of a read discards buffered lines, pipeline and FIFO.
        resetDut(2);
        i_data_ready = 1'b0;
        applyStimulus(8'd0); applyStimulus(8'd0); applyStimulus(8'd255);
        for (int c = 0; c < 4; c++) begin
            i_data_valid = 1'b1;
            i_data       = 8'd200;
            @(posedge axi_clk); #1;
        end
        resetDut(2);
        i_data_ready = 1'b1;
        foreach (pat_const[c]) exp_q.push_back(pat_const[c]);
        applyStimulus(8'd50); applyStimulus(8'd50); applyStimulus(8'd50);
        drain();
        checkOutput("rerst_outs", out_cnt, 8);
        checkOutput("rerst_intr", intr_cnt, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
